// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package avmm_pkg;

    localparam int unsigned AVMM_ADDR_W      = 32;
    localparam int unsigned AVMM_DATA_W      = 32;
    localparam int unsigned TIMEOUT_DISABLED = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } avmm_state_e;

    typedef struct packed {
        logic                   write;
        logic [AVMM_ADDR_W-1:0] addr;
        logic [AVMM_DATA_W-1:0] wdata;
    } avmm_cmd_t;

    typedef struct packed {
        logic                   is_write;
        logic                   err;
        logic [AVMM_DATA_W-1:0] rdata;
    } avmm_rsp_t;

endpackage

// File: rtl/avmm_wait_timer.sv
// Per-transaction waitrequest stall counter plus a saturating count of aborted transactions.
module avmm_wait_timer
    import avmm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 134217727,
    parameter int unsigned TO_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       tick_i,
    output logic       expired_o,
    output logic [7:0] timeout_count_o
);

    logic [TO_W-1:0] wait_q;
    logic [TO_W-1:0] wait_d;
    logic [7:0]      to_cnt_q;
    logic [7:0]      to_cnt_d;
    logic            at_limit_s;

    // The stall counter parks at TIMEOUT rather than wrapping.
    assign at_limit_s      = (wait_q == TO_W'(TIMEOUT));
    assign expired_o       = (TIMEOUT != TIMEOUT_DISABLED) && at_limit_s;
    assign timeout_count_o = to_cnt_q;

    // Next-state for the stall counter and the abort counter.
    always_comb begin
        wait_d   = wait_q;
        to_cnt_d = to_cnt_q;
        if (clear_i) begin
            wait_d = '0;
        end else if (tick_i && !at_limit_s) begin
            wait_d = wait_q + TO_W'(1);
        end else begin
            wait_d = wait_q;
        end
        // A tick while expired is exactly the abort condition seen by the FSM.
        if (tick_i && expired_o && (to_cnt_q != 8'hFF)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q   <= '0;
            to_cnt_q <= 8'd0;
        end else begin
            wait_q   <= wait_d;
            to_cnt_q <= to_cnt_d;
        end
    end

endmodule

// File: rtl/avmm_cmd_master.sv
// Issues one single-beat Avalon-MM read or write per command and returns one response,
// aborting with an error if the slave stalls for longer than TIMEOUT cycles.
module avmm_cmd_master
    import avmm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 134217727,
    parameter int unsigned TO_W    = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic [7:0]        timeout_count
);

    avmm_state_e       state_q;
    logic [ADDR_W-1:0] m_address_q;
    logic [DATA_W-1:0] m_writedata_q;
    logic              m_read_q;
    logic              m_write_q;
    logic              rsp_valid_q;
    logic              rsp_is_write_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              in_txn_s;
    logic              wt_clear_s;
    logic              wt_tick_s;
    logic              expired_s;

    // Handshake and busy are masked by reset so they read 0 while reset is held.
    assign cmd_ready    = (state_q == IDLE) && !reset;
    assign busy         = (state_q != IDLE) && !reset;
    assign in_txn_s     = (state_q == RD) || (state_q == WR);
    assign wt_clear_s   = (state_q == IDLE);
    assign wt_tick_s    = in_txn_s && m_waitrequest;

    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_write = rsp_is_write_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;

    avmm_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (wt_clear_s),
        .tick_i          (wt_tick_s),
        .expired_o       (expired_s),
        .timeout_count_o (timeout_count)
    );

    // Command FSM with registered Avalon strobes and response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        m_address_q   <= cmd_addr;
                        m_writedata_q <= cmd_wdata;
                        if (cmd_write) begin
                            m_write_q <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            m_read_q  <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                end
                RD, WR: begin
                    // A dropped waitrequest wins over an expiring counter on the same edge.
                    if (!m_waitrequest) begin
                        m_read_q       <= 1'b0;
                        m_write_q      <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        rsp_err_q      <= 1'b0;
                        rsp_is_write_q <= (state_q == WR);
                        rsp_rdata_q    <= (state_q == RD) ? m_readdata : '0;
                        state_q        <= RESP;
                    end else if (expired_s) begin
                        m_read_q       <= 1'b0;
                        m_write_q      <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        rsp_err_q      <= 1'b1;
                        rsp_is_write_q <= (state_q == WR);
                        rsp_rdata_q    <= '0;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Self-checking bench: directed vector table, randomized traffic against a transaction-level
// model, timeout saturation and reset-in-flight sequences.
module tb_avmm_cmd_master;
    import avmm_pkg::*;

    localparam int unsigned T = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_is_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        busy;
    logic [7:0]  timeout_count;

    always #5 clk = ~clk;

    avmm_cmd_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (T),
        .TO_W    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_is_write  (rsp_is_write),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    int checks   = 0;
    int failures = 0;
    int to_model = 0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          nstall;
        int          rdelay;
        logic        err;
        logic [31:0] rdata;
        int          cycles;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: a stall longer than T aborts after T+1 strobe cycles.
    function automatic void predict(input logic w, input logic [31:0] a, input int nstall,
                                    output avmm_rsp_t r, output int cycles);
        bit aborted;
        aborted    = (T != 0) && (nstall > int'(T));
        cycles     = aborted ? int'(T) + 1 : nstall + 1;
        r.is_write = w;
        r.err      = aborted;
        if (aborted || w) r.rdata = 32'd0;
        else r.rdata = model_mem.exists(a) ? (model_mem[a] << 1) : 32'd0;
    endfunction

    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int nstall, input int rdelay, input avmm_rsp_t exp, input int exp_cycles);
        int          cyc;
        logic [31:0] exp_strobe;
        exp_strobe = w ? 32'd2 : 32'd1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while ((m_read || m_write) && cyc < 64) begin
            chk("strobe_kind", {30'd0, m_write, m_read}, exp_strobe);
            chk("m_address_hold", m_address, a);
            if (w) chk("m_writedata_hold", m_writedata, d);
            chk("rsp_valid_in_txn", 32'(rsp_valid), 32'd0);
            chk("cmd_ready_in_txn", 32'(cmd_ready), 32'd0);
            m_waitrequest = (cyc < nstall);
            m_readdata    = slave_mem.exists(m_address) ? (slave_mem[m_address] << 1) : 32'd0;
            if (m_write && !m_waitrequest) slave_mem[m_address] = m_writedata;
            cyc++;
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        chk("strobe_cycles", 32'(cyc), 32'(exp_cycles));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_is_write", 32'(rsp_is_write), 32'(exp.is_write));
        chk("rsp_err", 32'(rsp_err), 32'(exp.err));
        chk("rsp_rdata", rsp_rdata, exp.rdata);
        for (int k = 0; k < rdelay; k++) begin
            cmd_valid = 1'b1;
            cmd_write = ~w;
            cmd_addr  = $urandom;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, exp.rdata);
            chk("bp_rsp_err", 32'(rsp_err), 32'(exp.err));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_no_strobe", {30'd0, m_write, m_read}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_ready", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("no_strobe_after_rsp", {30'd0, m_write, m_read}, 32'd0);
        if (w && !exp.err) model_mem[a] = d;
        if (exp.err && to_model < 255) to_model++;
        chk("timeout_count", 32'(timeout_count), 32'(to_model));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        avmm_rsp_t r;
        int        cyc_exp;
        logic      w;
        logic [31:0] a;
        logic [31:0] d;
        int        ns;

        vecs[0] = '{1'b1, 32'd5,          32'h12345678, 0,    0, 1'b0, 32'h00000000, 1};
        vecs[1] = '{1'b0, 32'd5,          32'h00000000, 0,    0, 1'b0, 32'h2468ACF0, 1};
        vecs[2] = '{1'b0, 32'd5,          32'h00000000, 10,   1, 1'b0, 32'h2468ACF0, 11};
        vecs[3] = '{1'b0, 32'd5,          32'h00000000, 12,   0, 1'b0, 32'h2468ACF0, 13};
        vecs[4] = '{1'b0, 32'd5,          32'h00000000, 13,   0, 1'b1, 32'h00000000, 13};
        vecs[5] = '{1'b1, 32'd9,          32'hDEADBEEF, 1000, 0, 1'b1, 32'h00000000, 13};
        vecs[6] = '{1'b0, 32'd9,          32'h00000000, 2,    0, 1'b0, 32'h00000000, 3};
        vecs[7] = '{1'b1, 32'hFFFFFFFF,   32'hA5A5A5A5, 3,    5, 1'b0, 32'h00000000, 4};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'h00000000, 0,    2, 1'b0, 32'h4B4B4B4A, 1};
        vecs[9] = '{1'b0, 32'd0,          32'h00000000, 1,    0, 1'b0, 32'h00000000, 2};

        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = 32'd0;
        cmd_wdata     = 32'd0;
        rsp_ready     = 1'b0;
        m_readdata    = 32'd0;
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'd0, m_write, m_read}, 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_rsp_flags", {29'd0, rsp_valid, rsp_err, rsp_is_write}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_timeout_count", 32'(timeout_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            r.is_write = vecs[i].w;
            r.err      = vecs[i].err;
            r.rdata    = vecs[i].rdata;
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].nstall, vecs[i].rdelay, r, vecs[i].cycles);
        end

        // Randomized traffic checked against the transaction model.
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            d  = $urandom;
            ns = $urandom_range(0, 15);
            predict(w, a, ns, r, cyc_exp);
            run_txn(w, a, d, ns, $urandom_range(0, 3), r, cyc_exp);
        end

        // Repeated stuck-slave aborts drive timeout_count into saturation.
        for (int i = 0; i < 300; i++) begin
            predict(1'b0, 32'd3, 1000, r, cyc_exp);
            run_txn(1'b0, 32'd3, 32'd0, 1000, 0, r, cyc_exp);
        end
        chk("timeout_saturated", 32'(timeout_count), 32'd255);

        // Reset while a read is stalled.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd7;
        @(negedge clk);
        cmd_valid     = 1'b0;
        m_waitrequest = 1'b1;
        chk("rir_m_read_up", 32'(m_read), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rir_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
        chk("rir_busy_in_reset", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rir_m_read_dropped", 32'(m_read), 32'd0);
        chk("rir_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rir_timeout_count", 32'(timeout_count), 32'd0);
        reset         = 1'b0;
        m_waitrequest = 1'b0;
        to_model      = 0;
        @(negedge clk);
        chk("rir_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("rir_busy_after", 32'(busy), 32'd0);

        // Reset while a response is pending discards it.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rresp_pending", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rresp_discarded", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rresp_cmd_ready", 32'(cmd_ready), 32'd1);

        predict(1'b0, 32'd5, 0, r, cyc_exp);
        run_txn(1'b0, 32'd5, 32'd0, 0, 0, r, cyc_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
